// File: rtl/adc_telemetry_pkg.sv
// Shared constants and types for the ADC telemetry framer.
// Frame geometry, default sync bytes and the framer state encoding live here.
package adc_telemetry_pkg;

    localparam int FRAME_LEN = 20;
    localparam int IDX_W     = 5;

    localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Upper byte of a channel pair: channel number tagged onto the top nibble.
    function automatic logic [7:0] chan_hi_byte(input logic [2:0] ch, input logic [11:0] value);
        return {1'b0, ch, value[11:8]};
    endfunction

endpackage

// File: rtl/adc_telemetry_framer_timer.sv
// Free-running frame period timer; emits a one-cycle tick every FRAME_PERIOD cycles.
// Disabling it parks the count at zero so the next enable starts a full period.
module telemetry_period_timer #(
    parameter int unsigned FRAME_PERIOD = 50000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    output logic oTICK
);

    localparam logic [23:0] LAST_COUNT = 24'(FRAME_PERIOD - 1);

    logic [23:0] count;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            count <= '0;
        end else if (!iEN) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 24'd1;
        end
    end

    assign oTICK = iEN && (count == LAST_COUNT);

endmodule

// File: rtl/adc_telemetry_framer.sv
// Snapshots the eight ADC channel registers on each period tick and streams them
// as a 20-byte framed packet (sync, sequence, channel data, checksum) to the UART TX.
module adc_telemetry_framer
    import adc_telemetry_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = 50000,
    parameter logic [7:0]  HDR0         = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1         = HDR1_DEFAULT
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [11:0] iADC_value0,
    input  logic [11:0] iADC_value1,
    input  logic [11:0] iADC_value2,
    input  logic [11:0] iADC_value3,
    input  logic [11:0] iADC_value4,
    input  logic [11:0] iADC_value5,
    input  logic [11:0] iADC_value6,
    input  logic [11:0] iADC_value7,
    output logic [7:0]  oTX_DATA,
    output logic        oTX_VALID,
    input  logic        iTX_READY,
    output logic        oBUSY,
    output logic [7:0]  oSEQ,
    output logic [7:0]  oOVR_CNT
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [11:0]      snap [8];
    logic [7:0]       csum;
    logic [7:0]       csum_next;
    logic [7:0]       next_byte;
    logic [IDX_W-1:0] nidx;
    logic [IDX_W-1:0] off;
    logic [2:0]       ch;
    logic             tick;
    logic             xfer;

    telemetry_period_timer #(
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_timer (
        .iCLK (iCLK),
        .iRST (iRST),
        .iEN  (iEN),
        .oTICK(tick)
    );

    assign xfer  = oTX_VALID && iTX_READY;
    assign oBUSY = (state != IDLE);

    // The byte register is preloaded with the byte after the one being accepted,
    // so the checksum byte must see the sum including the byte leaving this cycle.
    always_comb begin
        csum_next = csum;
        if (idx >= IDX_W'(2) && idx <= IDX_W'(18)) begin
            csum_next = csum + oTX_DATA;
        end
        nidx      = idx + IDX_W'(1);
        off       = nidx - IDX_W'(3);
        ch        = off[3:1];
        next_byte = 8'h00;
        if (nidx == IDX_W'(1)) begin
            next_byte = HDR1;
        end else if (nidx == IDX_W'(2)) begin
            next_byte = oSEQ;
        end else if (nidx == LAST_IDX) begin
            next_byte = csum_next;
        end else if (nidx >= IDX_W'(3) && nidx <= IDX_W'(18)) begin
            next_byte = off[0] ? snap[ch][7:0] : chan_hi_byte(ch, snap[ch]);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= IDLE;
            idx       <= '0;
            csum      <= '0;
            oTX_DATA  <= '0;
            oTX_VALID <= 1'b0;
            oSEQ      <= '0;
            oOVR_CNT  <= '0;
            for (int i = 0; i < 8; i++) begin
                snap[i] <= '0;
            end
        end else begin
            // A trigger that lands while any frame work is pending is lost, not queued.
            if (tick && state != IDLE && oOVR_CNT != 8'hFF) begin
                oOVR_CNT <= oOVR_CNT + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    snap[0]   <= iADC_value0;
                    snap[1]   <= iADC_value1;
                    snap[2]   <= iADC_value2;
                    snap[3]   <= iADC_value3;
                    snap[4]   <= iADC_value4;
                    snap[5]   <= iADC_value5;
                    snap[6]   <= iADC_value6;
                    snap[7]   <= iADC_value7;
                    idx       <= '0;
                    csum      <= '0;
                    oTX_DATA  <= HDR0;
                    oTX_VALID <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        csum <= csum_next;
                        if (idx == LAST_IDX) begin
                            oTX_VALID <= 1'b0;
                            oTX_DATA  <= '0;
                            oSEQ      <= oSEQ + 8'd1;
                            state     <= IDLE;
                        end else begin
                            idx      <= nidx;
                            oTX_DATA <= next_byte;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    oTX_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_telemetry_framer.sv
// Directed self-checking bench for adc_telemetry_framer with a short frame period.
// Expected bytes come from an independent frame-layout model plus hand-computed constants.
module tb_adc_telemetry_framer;

    localparam int unsigned FP = 32;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ready;
    logic [11:0] adc [8];
    logic [7:0]  txData;
    logic        txValid;
    logic        busy;
    logic [7:0]  seq;
    logic [7:0]  ovr;

    int          checks;
    int          failures;
    logic [11:0] expVals [8];
    logic [7:0]  got [20];
    int          waitCycles;
    logic        lateChange;
    logic [11:0] lateVal;
    logic [7:0]  readyPattern;
    logic [7:0]  expSeq;

    adc_telemetry_framer #(
        .FRAME_PERIOD(FP)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iEN        (en),
        .iADC_value0(adc[0]),
        .iADC_value1(adc[1]),
        .iADC_value2(adc[2]),
        .iADC_value3(adc[3]),
        .iADC_value4(adc[4]),
        .iADC_value5(adc[5]),
        .iADC_value6(adc[6]),
        .iADC_value7(adc[7]),
        .oTX_DATA   (txData),
        .oTX_VALID  (txValid),
        .iTX_READY  (ready),
        .oBUSY      (busy),
        .oSEQ       (seq),
        .oOVR_CNT   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame byte i for sequence s, built straight from the packet layout.
    function automatic logic [7:0] modelByte(input int i, input logic [7:0] s);
        int k;
        logic [7:0] sum;
        if (i == 0) return 8'hA5;
        if (i == 1) return 8'h5A;
        if (i == 2) return s;
        if (i == 19) begin
            sum = 8'h00;
            for (int j = 2; j <= 18; j++) sum = sum + modelByte(j, s);
            return sum;
        end
        k = (i - 3) / 2;
        if (((i - 3) % 2) == 0) return {1'b0, k[2:0], expVals[k][11:8]};
        return expVals[k][7:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [11:0] value);
        adc[ch]     = value;
        expVals[ch] = value;
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] s);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, modelByte(i, s)});
        end
    endtask

    // mode 0: always ready; 1: patterned backpressure; 2: 40-cycle stall with timer left running
    task automatic collectFrame(input int mode);
        int cyc;
        int n;
        int stepI;
        logic prevStall;
        logic [7:0] prevData;
        en    = 1'b1;
        ready = (mode == 2) ? 1'b0 : 1'b1;
        cyc   = 0;
        while (!txValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        waitCycles = cyc;
        checkOutput("wait_valid", {31'h0, txValid}, 32'h1);
        if (lateChange) adc[0] = lateVal;
        if (mode == 2) begin
            for (int i = 0; i < 40; i++) begin
                checkOutput("stall_hold", {24'h0, txData}, 32'hA5);
                @(negedge clk);
            end
        end
        en        = 1'b0;
        n         = 0;
        stepI     = 0;
        prevStall = 1'b0;
        prevData  = 8'h00;
        while (n < 20 && stepI < 200) begin
            if (prevStall) checkOutput("stall_stable", {24'h0, txData}, {24'h0, prevData});
            ready = (mode == 1) ? readyPattern[stepI % 8] : 1'b1;
            if (txValid && ready) begin
                got[n]    = txData;
                n++;
                prevStall = 1'b0;
            end else begin
                prevStall = txValid;
                prevData  = txData;
            end
            @(negedge clk);
            stepI++;
        end
        ready = 1'b1;
        checkOutput("xfer_count", n, 20);
        checkOutput("valid_drop", {31'h0, txValid}, 32'h0);
    endtask

    initial begin
        int cyc;
        checks       = 0;
        failures     = 0;
        lateChange   = 1'b0;
        lateVal      = 12'h000;
        readyPattern = 8'b0110_1101;
        rst          = 1'b0;
        en           = 1'b0;
        ready        = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(i, 12'h000);

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", {31'h0, txValid}, 32'h0);
        checkOutput("rst_data", {24'h0, txData}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_seq", {24'h0, seq}, 32'h0);
        checkOutput("rst_ovr", {24'h0, ovr}, 32'h0);
        rst = 1'b1;

        // All-zero channels: tick after 32 cycles, valid two edges later.
        collectFrame(0);
        checkOutput("f0_latency", waitCycles, 33);
        checkFrame("f0", 8'h00);
        checkOutput("f0_csum", {24'h0, got[19]}, 32'hC0);
        checkOutput("f0_seq_after", {24'h0, seq}, 32'h01);

        // Channel 3 packing.
        applyStimulus(3, 12'hABC);
        collectFrame(0);
        checkFrame("f1", 8'h01);
        checkOutput("f1_b9", {24'h0, got[9]}, 32'h3A);
        checkOutput("f1_b10", {24'h0, got[10]}, 32'hBC);
        checkOutput("f1_csum", {24'h0, got[19]}, 32'h87);

        // Backpressure must not change the byte sequence.
        collectFrame(1);
        checkFrame("bp", 8'h02);
        checkOutput("bp_ovr", {24'h0, ovr}, 32'h0);

        // Long stall with the timer running drops exactly one trigger.
        collectFrame(2);
        checkFrame("ovr", 8'h03);
        checkOutput("ovr_seq_byte", {24'h0, got[2]}, 32'h03);
        checkOutput("ovr_cnt", {24'h0, ovr}, 32'h01);
        checkOutput("ovr_seq_after", {24'h0, seq}, 32'h04);

        // Input change after LOAD is not seen by the frame in flight.
        applyStimulus(0, 12'h123);
        lateChange = 1'b1;
        lateVal    = 12'h555;
        collectFrame(0);
        lateChange = 1'b0;
        checkFrame("snap", 8'h04);
        checkOutput("snap_b3", {24'h0, got[3]}, 32'h01);
        checkOutput("snap_b4", {24'h0, got[4]}, 32'h23);
        applyStimulus(0, 12'h555);

        // Mid-frame reset after bytes 0..7 have transferred.
        applyStimulus(2, 12'h7E4);
        en  = 1'b1;
        cyc = 0;
        while (!txValid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("mr_wait_valid", {31'h0, txValid}, 32'h1);
        en = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("mr_byte8", {24'h0, txData}, 32'hE4);
        #2 rst = 1'b0;
        #1;
        checkOutput("mr_valid", {31'h0, txValid}, 32'h0);
        checkOutput("mr_seq", {24'h0, seq}, 32'h0);
        checkOutput("mr_busy", {31'h0, busy}, 32'h0);
        checkOutput("mr_ovr", {24'h0, ovr}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        collectFrame(0);
        checkFrame("mr_restart", 8'h00);
        checkOutput("mr_restart_hdr", {24'h0, got[0]}, 32'hA5);

        // Sequence wrap: frames 1..255 then 0.
        expSeq = 8'h01;
        for (int f = 0; f < 256; f++) begin
            collectFrame(0);
            checkOutput($sformatf("wrap_seq_%0d", f), {24'h0, got[2]}, {24'h0, expSeq});
            expSeq = expSeq + 8'd1;
        end
        checkOutput("wrap_last_csum", {24'h0, got[19]}, {24'h0, modelByte(19, 8'h00)});
        checkOutput("wrap_seq_after", {24'h0, seq}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
